divider_sequencer: RTL and testbench

//   Control FSM for the unsigned restoring divider datapath. It sequences the divisor

---
 rtl/divider_sequencer.sv | 110 +++++++++++
 tb/tb_divider_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_sequencer.sv
// Control FSM for the unsigned restoring divider: LOAD, WIDTH shift/subtract steps, ADJUST, DONE.
// Optional divide-by-zero short-cut is enabled with `define DIV_BY_ZERO_DETECT_EN.
module divider_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             divisor_zero,
    output logic             w_ctrl_reg1,
    output logic             w_ctrl_reg2,
    output logic             SLL_ctrl,
    output logic             SRL_ctrl,
    output logic             busy,
    output logic             rdy,
    output logic [CNT_W-1:0] iter_cnt
`ifdef DIV_BY_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_ADJUST,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifndef DIV_BY_ZERO_DETECT_EN
    logic unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
`ifdef DIV_BY_ZERO_DETECT_EN
                if (divisor_zero) state_d = S_DONE;
`endif
            end
            S_SHIFT: begin
                if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
                if (cnt_q >= CNT_LAST) state_d = S_ADJUST;
            end
            S_ADJUST: state_d = S_DONE;
            S_DONE: begin
                if (!run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet still
    // line up with the state register on every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            w_ctrl_reg1 <= 1'b0;
            w_ctrl_reg2 <= 1'b0;
            SLL_ctrl    <= 1'b0;
            SRL_ctrl    <= 1'b0;
            busy        <= 1'b0;
            rdy         <= 1'b0;
`ifdef DIV_BY_ZERO_DETECT_EN
            div_zero    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_ctrl_reg1 <= (state_d == S_LOAD);
            w_ctrl_reg2 <= (state_d == S_LOAD);
            SLL_ctrl    <= (state_d == S_SHIFT);
            SRL_ctrl    <= (state_d == S_ADJUST);
            busy        <= (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_ADJUST);
            rdy         <= (state_d == S_DONE);
`ifdef DIV_BY_ZERO_DETECT_EN
            if (state_q == S_IDLE && state_d == S_LOAD) div_zero <= 1'b0;
            else if (state_q == S_LOAD && state_d == S_DONE) div_zero <= 1'b1;
`endif
        end
    end

    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Self-checking bench for divider_sequencer with a behavioural restoring-divider datapath.
// Build with +define+DIV_BY_ZERO_DETECT_EN to exercise the divide-by-zero short-cut.
module tb_divider_sequencer;

    localparam int W  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          divisor_zero;
    logic          w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy;
    logic [CW-1:0] iter_cnt;
`ifdef DIV_BY_ZERO_DETECT_EN
    logic          div_zero;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] tb_dividend = '0;
    logic [31:0] tb_divisor  = 32'd1;
    logic [31:0] dp_divisor  = '0;
    logic [64:0] dp_rem      = '0;
    logic [5:0]  obs;

    assign divisor_zero = (tb_divisor == 32'd0);
    assign obs = {w_ctrl_reg1, w_ctrl_reg2, SLL_ctrl, SRL_ctrl, busy, rdy};

    always #5 clk = ~clk;

    divider_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .divisor_zero (divisor_zero),
        .w_ctrl_reg1  (w_ctrl_reg1),
        .w_ctrl_reg2  (w_ctrl_reg2),
        .SLL_ctrl     (SLL_ctrl),
        .SRL_ctrl     (SRL_ctrl),
        .busy         (busy),
        .rdy          (rdy),
        .iter_cnt     (iter_cnt)
`ifdef DIV_BY_ZERO_DETECT_EN
        ,
        .div_zero     (div_zero)
`endif
    );

    // Restoring datapath, sampling the controls on the falling edge.
    always @(negedge clk) begin
        logic [32:0] hi;
        logic        q;
        if (w_ctrl_reg1) dp_divisor <= tb_divisor;
        if (w_ctrl_reg2) dp_rem <= {32'b0, tb_dividend, 1'b0};
        if (SLL_ctrl) begin
            hi = dp_rem[64:32];
            q  = (hi >= {1'b0, dp_divisor});
            if (q) hi = hi - {1'b0, dp_divisor};
            dp_rem <= {hi[31:0], dp_rem[31:0], q};
        end
        if (SRL_ctrl) dp_rem[64:32] <= dp_rem[64:32] >> 1;
    end

    // Reference model: phase 0 IDLE, 1 LOAD, 2 SHIFT, 3 ADJUST, 4 DONE.
    // Offset n = number of rising edges after the one that sampled run.
    function automatic int phase_at(input int n, input bit run_held);
        if (n == 0) return 1;
        if (n <= W) return 2;
        if (n == W + 1) return 3;
        if (n == W + 2 || run_held) return 4;
        return 0;
    endfunction

    function automatic int cnt_at(input int n, input bit run_held);
        if (n == 0) return 0;
        if (n <= W) return n - 1;
        if (n <= W + 2 || run_held) return W;
        return 0;
    endfunction

    function automatic logic [5:0] ctrl_of(input int ph);
        case (ph)
            1: return 6'b110010;
            2: return 6'b001010;
            3: return 6'b000110;
            4: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic pulse_run();
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs !== 6'b0 || iter_cnt !== '0)
            $display("FAIL reset_idle: ctrl=%b cnt=%0d required ctrl=000000 cnt=0", obs, iter_cnt);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        run = 1'b1;
        for (int n = 0; n <= 11; n++) begin
            @(negedge clk);
            if (n == 0) run = 1'b0;
        end
        n_chk++;
        if (iter_cnt !== CW'(10) || SLL_ctrl !== 1'b1)
            $display("FAIL reset_pre: cnt=%0d sll=%b required cnt=10 sll=1", iter_cnt, SLL_ctrl);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (obs !== 6'b0 || iter_cnt !== '0)
            $display("FAIL reset_async: ctrl=%b cnt=%0d required ctrl=000000 cnt=0", obs, iter_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs !== 6'b0 || iter_cnt !== '0)
            $display("FAIL reset_stay_idle: ctrl=%b cnt=%0d required ctrl=000000 cnt=0", obs, iter_cnt);
        else n_pass++;
    endtask

    task automatic test_timing();
        int n_w2 = 0, n_sll = 0, n_srl = 0, first_rdy = -1;
        int bad = 0;
        tb_divisor = 32'd3;
        pulse_run();
        for (int n = 0; n <= W + 5; n++) begin
            if (n > 0) @(negedge clk);
            n_chk++;
            if (obs !== ctrl_of(phase_at(n, 1'b0)) || iter_cnt !== CW'(cnt_at(n, 1'b0))) begin
                if (bad < 4)
                    $display("FAIL timing_cycle%0d: ctrl=%b cnt=%0d required ctrl=%b cnt=%0d",
                             n, obs, iter_cnt, ctrl_of(phase_at(n, 1'b0)), cnt_at(n, 1'b0));
                bad++;
            end else n_pass++;
            n_w2  += int'(w_ctrl_reg2);
            n_sll += int'(SLL_ctrl);
            n_srl += int'(SRL_ctrl);
            if (rdy && first_rdy < 0) first_rdy = n;
        end
        n_chk++;
        if (n_w2 != 1 || n_sll != W || n_srl != 1)
            $display("FAIL timing_widths: w2=%0d sll=%0d srl=%0d required 1/%0d/1", n_w2, n_sll, n_srl, W);
        else n_pass++;
        n_chk++;
        if (first_rdy != W + 2)
            $display("FAIL timing_latency: rdy at %0d required %0d", first_rdy, W + 2);
        else n_pass++;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_q, exp_r;
        int guard = 0;
        tb_dividend = a;
        tb_divisor  = b;
        exp_q = (b == 0) ? 32'hFFFF_FFFF : a / b;
        exp_r = (b == 0) ? a : a % b;
        pulse_run();
        while (!rdy && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        n_chk++;
        if (!rdy)
            $display("FAIL div_timeout: %0d/%0d rdy=%b required 1", a, b, rdy);
        else if (dp_rem[31:0] !== exp_q || dp_rem[63:32] !== exp_r)
            $display("FAIL div_result: %0d/%0d q=%0d r=%0d required q=%0d r=%0d",
                     a, b, dp_rem[31:0], dp_rem[63:32], exp_q, exp_r);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_datapath();
        logic [31:0] a, b;
        run_div(32'd100, 32'd7);
        run_div(32'hFFFF_FFFF, 32'd1);
        run_div(32'd5, 32'd9);
        run_div(32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == 0) b = 32'd13;
            run_div(a, b);
        end
`ifndef DIV_BY_ZERO_DETECT_EN
        run_div(32'h1234_5678, 32'd0);
`endif
        tb_divisor = 32'd1;
    endtask

    task automatic test_handshake();
        int first_rdy = -1;
        @(negedge clk);
        run = 1'b1;
        for (int n = 0; n <= W + 10 && first_rdy < 0; n++) begin
            @(negedge clk);
            if (rdy) first_rdy = n;
        end
        n_chk++;
        if (first_rdy != W + 2)
            $display("FAIL handshake_latency: rdy at %0d required %0d", first_rdy, W + 2);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== ctrl_of(4) || iter_cnt !== CW'(W))
                $display("FAIL handshake_hold%0d: ctrl=%b cnt=%0d required ctrl=%b cnt=%0d",
                         k, obs, iter_cnt, ctrl_of(4), W);
            else n_pass++;
        end
        run = 1'b0;
        @(negedge clk);
        n_chk++;
        if (obs !== 6'b0 || iter_cnt !== '0)
            $display("FAIL handshake_release: ctrl=%b cnt=%0d required ctrl=000000 cnt=0", obs, iter_cnt);
        else n_pass++;
    endtask

    task automatic test_ignore_abort();
        int first_rdy = -1;
        @(negedge clk);
        run = 1'b1;
        for (int n = 0; n <= W + 10 && first_rdy < 0; n++) begin
            @(negedge clk);
            if (n == 6) begin
                n_chk++;
                if (iter_cnt !== CW'(5))
                    $display("FAIL abort_cnt: cnt=%0d required 5", iter_cnt);
                else n_pass++;
                run = 1'b0;
            end
            if (rdy) first_rdy = n;
        end
        n_chk++;
        if (first_rdy != W + 2)
            $display("FAIL abort_latency: rdy at %0d required %0d", first_rdy, W + 2);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_div_zero();
        int first_rdy = -1, n_sll = 0;
        tb_dividend = $urandom;
        tb_divisor  = 32'd0;
        pulse_run();
        for (int n = 0; n <= W + 10 && first_rdy < 0; n++) begin
            if (n > 0) @(negedge clk);
            n_sll += int'(SLL_ctrl);
            if (rdy) first_rdy = n;
        end
`ifdef DIV_BY_ZERO_DETECT_EN
        n_chk++;
        if (first_rdy != 1 || n_sll != 0 || div_zero !== 1'b1 || iter_cnt !== '0)
            $display("FAIL dz_short: rdy at %0d sll=%0d dz=%b cnt=%0d required rdy at 1 sll=0 dz=1 cnt=0",
                     first_rdy, n_sll, div_zero, iter_cnt);
        else n_pass++;
        repeat (2) @(negedge clk);
        tb_divisor = 32'd4;
        pulse_run();
        n_chk++;
        if (div_zero !== 1'b0 || w_ctrl_reg1 !== 1'b1)
            $display("FAIL dz_clear: dz=%b load=%b required dz=0 load=1", div_zero, w_ctrl_reg1);
        else n_pass++;
        repeat (W + 4) @(negedge clk);
`else
        n_chk++;
        if (first_rdy != W + 2 || n_sll != W)
            $display("FAIL dz_full: rdy at %0d sll=%0d required rdy at %0d sll=%0d",
                     first_rdy, n_sll, W + 2, W);
        else n_pass++;
        repeat (2) @(negedge clk);
`endif
        tb_divisor = 32'd1;
    endtask

    initial begin
        test_reset();
        test_timing();
        repeat (2) @(negedge clk);
        test_datapath();
        test_handshake();
        test_ignore_abort();
        test_div_zero();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
